// File: rtl/pending_instr_tracker_pkg.sv
// Shared types, widths and warp-id decode helper for the
// pending instruction tracker.
package pending_instr_tracker_pkg;

  localparam int MAX_WARPS     = 32;
  localparam int NUM_WARPS_DEF = 4;
  localparam int ISSUE_W_DEF   = 1;
  localparam int MAX_PEND_DEF  = 15;

  localparam int PENDING_CTR_W = $clog2(MAX_PEND_DEF + 1);

  typedef logic [MAX_WARPS-1:0] warp_oh_t;

  // One-hot of wid over the first nw warps; zero when out of range.
  function automatic warp_oh_t wid_decode(
    input logic [31:0] wid,
    input int unsigned nw
  );
    warp_oh_t oh;
    oh = '0;
    if (wid < nw)
      oh[wid[4:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pending_instr_tracker_ctr.sv
// One warp's in-flight counter: cnt + inc - dec each cycle,
// clamped at zero with an underflow pulse.
// Ports: clk, reset, inc, dec -> cnt, nonzero, underflow.
module pending_warp_ctr #(
  parameter int CTR_W = 4,
  parameter int DEC_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CTR_W-1:0] cnt,
  output logic             nonzero,
  output logic             underflow
);

  localparam int SW = CTR_W + DEC_W + 1;

  logic [SW-1:0] sum;

  // Two's-complement sum; sign bit set means more retired
  // than were outstanding.
  assign sum       = SW'(cnt) + SW'(inc) - SW'(dec);
  assign underflow = sum[SW-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      nonzero <= 1'b0;
    end else if (underflow) begin
      cnt     <= '0;
      nonzero <= 1'b0;
    end else begin
      cnt     <= sum[CTR_W-1:0];
      nonzero <= |sum[SW-2:0];
    end
  end

endmodule

// File: rtl/pending_instr_tracker.sv
// Per-warp in-flight instruction tracker between dispatch and commit.
// Ports: clk, reset, incr_*, decr_* -> pending_mask, all_idle, err_underflow.
module pending_instr_tracker
  import pending_instr_tracker_pkg::*;
#(
  parameter int NUM_WARPS   = NUM_WARPS_DEF,
  parameter int ISSUE_WIDTH = ISSUE_W_DEF,
  parameter int MAX_PENDING = MAX_PEND_DEF,
  localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            incr_valid,
  input  logic [NW_WIDTH-1:0]             incr_wid,
  output logic                            incr_ready,
  input  logic [ISSUE_WIDTH-1:0]          decr_valid,
  input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] decr_wid,
  output logic [NUM_WARPS-1:0]            pending_mask,
  output logic                            all_idle,
  output logic                            err_underflow
);

  localparam int CTR_W = $clog2(MAX_PENDING + 1);
  localparam int DEC_W = $clog2(ISSUE_WIDTH + 1);

  logic [NUM_WARPS-1:0] inc_oh;
  logic [NUM_WARPS-1:0] lane_oh [ISSUE_WIDTH];
  logic [DEC_W-1:0]     dec_cnt [NUM_WARPS];
  logic [CTR_W-1:0]     cnt     [NUM_WARPS];
  logic [NUM_WARPS-1:0] nonzero;
  logic [NUM_WARPS-1:0] uflow;

  assign inc_oh = NUM_WARPS'(
    wid_decode(32'(incr_wid), NUM_WARPS));

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
    assign lane_oh[i] = decr_valid[i]
      ? NUM_WARPS'(wid_decode(
          32'(decr_wid[i*NW_WIDTH +: NW_WIDTH]), NUM_WARPS))
      : '0;
  end

  // Several lanes may retire the same warp in one cycle.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      dec_cnt[w] = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++)
        dec_cnt[w] = dec_cnt[w] + DEC_W'(lane_oh[i][w]);
    end
  end

  // Looks only at registered counts, not same-cycle commits,
  // so there is no commit-to-dispatch timing path.
  always_comb begin
    incr_ready = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++)
      if (inc_oh[w] && cnt[w] == CTR_W'(MAX_PENDING))
        incr_ready = 1'b0;
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    pending_warp_ctr #(
      .CTR_W (CTR_W),
      .DEC_W (DEC_W)
    ) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .inc       (incr_valid & incr_ready & inc_oh[w]),
      .dec       (dec_cnt[w]),
      .cnt       (cnt[w]),
      .nonzero   (nonzero[w]),
      .underflow (uflow[w])
    );
  end

  assign pending_mask = nonzero;
  assign all_idle     = &(~nonzero);

  always_ff @(posedge clk) begin
    if (reset)
      err_underflow <= 1'b0;
    else if (|uflow)
      err_underflow <= 1'b1;
  end

endmodule
